// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the factorial accelerator control unit.
//   - state encodings S_IDLE..S_ERR (codes 6 and 7 are unused/illegal)
//   - control word constants and bit indices of the six control fields
//   - N_MAX: largest n whose factorial fits the 32-bit result bus
//   - cw_decode(): state -> control word lookup shared by the controller
// -----------------------------------------------------------------------------
package fact_pkg;

  localparam int CW_W  = 6;
  localparam int ST_W  = 3;
  localparam int N_MAX = 12;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Control word bit positions
  localparam int CW_EN_D   = 5;
  localparam int CW_MUX_S0 = 4;
  localparam int CW_MUX_S1 = 3;
  localparam int CW_CNT_LD = 2;
  localparam int CW_CNT_UD = 1;
  localparam int CW_CNT_CE = 0;

  // IDLE/CHECK/ERR and illegal codes: nothing enabled, result bus driven to 0.
  localparam logic [CW_W-1:0] CW_IDLE = 6'b000000;
  // D <= 1, counter <= n (load wins over count enable in the datapath).
  localparam logic [CW_W-1:0] CW_LOAD = 6'b100101;
  // D <= counter * D, counter counts down.
  localparam logic [CW_W-1:0] CW_MULT = 6'b110001;
  // Drive D onto the result bus.
  localparam logic [CW_W-1:0] CW_OUT  = 6'b001000;

  function automatic logic [CW_W-1:0] cw_decode(input state_e st);
    logic [CW_W-1:0] cw;
    cw = CW_IDLE;
    case (st)
      S_LOAD:  cw = CW_LOAD;
      S_MULT:  cw = CW_MULT;
      S_DONE:  cw = CW_OUT;
      default: cw = CW_IDLE;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/fact_ctrl.sv
// -----------------------------------------------------------------------------
// fact_ctrl
// Moore control unit for the factorial datapath. Sequences load and
// multiply/decrement steps from the datapath status flags and provides a
// go/done/err handshake to the wrapper.
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   go              in   start request (level, held until done/err seen)
//   cnt_out         in   datapath flag: counter < 2
//   in_gt_12        in   datapath flag: n > 12 (looked at only in IDLE)
//   control_signals out  {en_D, mux_s0, mux_s1, cnt_ld, cnt_ud, cnt_ce}
//   done            out  result valid on datapath result bus
//   err             out  n out of range, nothing computed
//   busy            out  computation in progress
//   state           out  current state code (debug)
//
// Build option FACT_CTRL_FAST_EN: MULT repeats back-to-back until the counter
// flag says < 2, visiting CHECK only once after LOAD. Without it MULT and
// CHECK alternate.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for go; decides LOAD vs ERR from in_gt_12
// LOAD  | D <= 1, counter <= n
// CHECK | test counter < 2
// MULT  | D <= counter * D, counter--
// DONE  | result on bus, wait for go to drop
// ERR   | n out of range, wait for go to drop
// 6,7   | illegal, recover to IDLE
// -----------------------------------------------------------------------------
module fact_ctrl
  import fact_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            cnt_out,
  input  logic            in_gt_12,
  output logic [CW_W-1:0] control_signals,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic [ST_W-1:0] state
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = in_gt_12 ? S_ERR : S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: state_d = cnt_out ? S_DONE : S_MULT;
      S_MULT: begin
`ifdef FACT_CTRL_FAST_EN
        // Final pass multiplies by 1 and decrements to 0, so D is unchanged.
        state_d = cnt_out ? S_DONE : S_MULT;
`else
        state_d = S_CHECK;
`endif
      end
      S_DONE:  state_d = go ? S_DONE : S_IDLE;
      S_ERR:   state_d = go ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    control_signals = cw_decode(state_q);
    done            = (state_q == S_DONE);
    err             = (state_q == S_ERR);
    busy            = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                      (state_q == S_MULT);
    state           = state_q;
  end

endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Control unit for the factorial accelerator: the other end of the datapath's control/status interface.
- Consumes status flags cnt_out and in_gt_12, sequences a 4-bit n through load / multiply-decrement, and drives the 6-bit control word.
- Provides a go/done/err handshake to the SoC-side wrapper.
- Together with the datapath, forms the factorial core: result = n! for n <= 12, error for n > 12.

Parameters:
- CW_W, 6, control word width (fixed by datapath).
- ST_W, 3, state register width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request from wrapper; level, held until done/err is seen.
- cnt_out  in  1  datapath flag: counter value < 2.
- in_gt_12  in  1  datapath flag: n > 12.
- control_signals  out  6  bit 5 en_D, 4 mux_s0, 3 mux_s1, 2 cnt_ld, 1 cnt_ud, 0 cnt_ce.
- done  out  1  result valid on the datapath result bus.
- err  out  1  n out of range; no computation done.
- busy  out  1  computation in progress.
- state  out  3  current state, for debug.

Behaviour:
- Control word semantics:
  - mux_s0=0 loads constant 1 into D; mux_s0=1 loads the product.
  - mux_s1=1 drives D to the result bus; mux_s1=0 drives 0.
  - cnt_ud=0 counts down.
- Moore FSM; all outputs decode from state only, registered state.
- States, control word, and transitions:
  - IDLE (0), cw=000000: go&!in_gt_12 -> LOAD; go&in_gt_12 -> ERR; else stay.
  - LOAD (1), cw=100101 (D<=1, counter<=n): -> CHECK.
  - CHECK (2), cw=000000: cnt_out -> DONE; else -> MULT.
  - MULT (3), cw=110001 (D<=counter*D, counter--): -> CHECK.
  - DONE (4), cw=001000, done=1: !go -> IDLE; else stay, with result held stable.
  - ERR (5), cw=000000, err=1: !go -> IDLE; else stay.
  - Codes 6 and 7 are illegal and go to IDLE next cycle, cw=000000.
- busy=1 in LOAD, CHECK, MULT.
- in_gt_12 is sampled only in IDLE.
- go is ignored outside IDLE, DONE and ERR; deasserting go mid-computation does not abort.
- Latency (go sampled at edge 0): DONE entered at cycle 2*max(n,1)+1.
  - n=0 and n=1 both give result 1.
- A new go while still in DONE/ERR has no effect until go has been low for one cycle (back in IDLE).
- Reset:
  - Reset in any state gives IDLE next edge.
  - On that edge: control_signals=000000, done=0, err=0, busy=0, state=0.
  - The datapath is reset by the same rst.
- Maximum n=12 gives 479001600, which fits 32 bits; no overflow handling is needed.

Optional Feature:
- Macro FACT_CTRL_FAST_EN.
- When defined:
  - MULT self-loops while cnt_out=0.
  - cnt_out=1 in MULT goes to DONE; that last MULT cycle multiplies by 1 and decrements to 0, so the result is unchanged.
  - CHECK is visited only once, right after LOAD.
  - DONE is entered at cycle n+3 for n>=2, and at cycle 3 for n<2.
- When undefined: the baseline alternating MULT/CHECK sequence.

Decomposition:
- Shared package fact_pkg holds:
  - state encodings S_IDLE..S_ERR;
  - control word constants CW_IDLE, CW_LOAD, CW_MULT, CW_OUT;
  - bit index constants for the six control fields;
  - constant N_MAX=12.
- Single module, no sub-module: next-state logic plus output decode.
- Top-level fact_top instantiates fact_ctrl and the datapath.

Test Plan:
- n=5, go held high: DONE at cycle 11 (FAST_EN: 8); integrated result=120; done=1 until go drops; IDLE the cycle after go=0.
- n=0, then n=1: DONE at cycle 3, result=1; control_signals never shows 110001.
- n=12: result=479001600 (0x1C8CFC00); DONE at cycle 25 (FAST_EN: 15).
- n=13: ERR at cycle 1, err=1, control_signals=000000, result=0; no LOAD is ever entered.
- rst asserted in MULT with n=7: next edge state=0, all outputs 0; a subsequent go with n=3 gives result 6.
- go held high through DONE, then dropped for 1 cycle and reasserted with n=4: exactly one new computation, result=24.
